// File: rtl/layer_param_store.sv
// Per-layer weight/bias parameter memory: a host stream loader assembles narrow beats
// into wide weight words and then bias entries; two independent 1-cycle read ports.
module layer_param_store #(
  parameter int DEPTH             = 1024,
  parameter int WEIGHT_DATA_WIDTH = 512,
  parameter int BIAS_DATA_WIDTH   = 2,
  parameter int ADDR_WIDTH        = 10,
  parameter int HOST_WIDTH        = 32
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         load_start,
  input  logic [HOST_WIDTH-1:0]        host_data,
  input  logic                         host_valid,
  output logic                         host_ready,
  output logic                         load_done,
  output logic                         loaded,
  output logic                         busy,
  input  logic                         weight_ren,
  input  logic [ADDR_WIDTH-1:0]        weight_addr,
  output logic [WEIGHT_DATA_WIDTH-1:0] weight_data,
  input  logic                         bias_ren,
  input  logic [ADDR_WIDTH-1:0]        bias_addr,
  output logic [BIAS_DATA_WIDTH-1:0]   bias_data,
  output logic                         rd_err
);

  localparam int BEATS  = WEIGHT_DATA_WIDTH / HOST_WIDTH;
  localparam int BEAT_W = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam int IDX_W  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int AW1    = ADDR_WIDTH + 1;
  localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(BEATS - 1);
  localparam logic [IDX_W-1:0]  LAST_IDX  = IDX_W'(DEPTH - 1);
  localparam logic [AW1-1:0]    DEPTH_LIM = AW1'(DEPTH);

  typedef enum logic [1:0] {IDLE, LOAD_W, LOAD_B} state_t;

  state_t                       state_q, state_d;
  logic [BEAT_W-1:0]            beat_cnt_q;
  logic [IDX_W-1:0]             word_addr_q;
  logic [WEIGHT_DATA_WIDTH-1:0] asm_q, asm_d;
  logic                         loaded_q, load_done_q, rd_err_q;
  logic [WEIGHT_DATA_WIDTH-1:0] weight_data_q;
  logic [BIAS_DATA_WIDTH-1:0]   bias_data_q;

  logic [WEIGHT_DATA_WIDTH-1:0] weight_mem [DEPTH];
  logic [BIAS_DATA_WIDTH-1:0]   bias_mem   [DEPTH];

  logic beat_fire, last_beat, last_word, w_oob, b_oob, w_bad, b_bad;

  assign beat_fire = host_valid && host_ready;
  assign last_beat = (beat_cnt_q == LAST_BEAT);
  assign last_word = (word_addr_q == LAST_IDX);
  assign w_oob     = ({1'b0, weight_addr} >= DEPTH_LIM);
  assign b_oob     = ({1'b0, bias_addr} >= DEPTH_LIM);
  assign w_bad     = busy || w_oob;
  assign b_bad     = busy || b_oob;

  // Current beat merged into the partially assembled word; written whole on the last beat.
  always_comb begin
    asm_d = asm_q;
    asm_d[beat_cnt_q*HOST_WIDTH +: HOST_WIDTH] = host_data;
  end

  always_ff @(posedge clk) begin
    if (!rst) state_q <= IDLE;
    else      state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (load_start) state_d = LOAD_W;
      LOAD_W:  if (beat_fire && last_beat && last_word) state_d = LOAD_B;
      LOAD_B:  if (beat_fire && last_word) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    host_ready = 1'b0;
    busy       = 1'b0;
    case (state_q)
      LOAD_W, LOAD_B: begin
        host_ready = 1'b1;
        busy       = 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      beat_cnt_q  <= '0;
      word_addr_q <= '0;
      asm_q       <= '0;
      loaded_q    <= 1'b0;
      load_done_q <= 1'b0;
    end else begin
      load_done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (load_start) begin
            beat_cnt_q  <= '0;
            word_addr_q <= '0;
            loaded_q    <= 1'b0;
          end
        end
        LOAD_W: begin
          if (beat_fire) begin
            asm_q <= asm_d;
            if (last_beat) begin
              beat_cnt_q  <= '0;
              word_addr_q <= last_word ? '0 : word_addr_q + 1'b1;
            end else begin
              beat_cnt_q <= beat_cnt_q + 1'b1;
            end
          end
        end
        LOAD_B: begin
          if (beat_fire) begin
            if (last_word) begin
              word_addr_q <= '0;
              loaded_q    <= 1'b1;
              load_done_q <= 1'b1;
            end else begin
              word_addr_q <= word_addr_q + 1'b1;
            end
          end
        end
        default: ;
      endcase
    end
  end

  // Array contents deliberately survive reset.
  always_ff @(posedge clk) begin
    if (state_q == LOAD_W && beat_fire && last_beat)
      weight_mem[word_addr_q] <= asm_d;
    if (state_q == LOAD_B && beat_fire)
      bias_mem[word_addr_q] <= host_data[BIAS_DATA_WIDTH-1:0];
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      weight_data_q <= '0;
      bias_data_q   <= '0;
    end else begin
      if (weight_ren)
        weight_data_q <= w_bad ? '0 : weight_mem[weight_addr[IDX_W-1:0]];
      if (bias_ren)
        bias_data_q <= b_bad ? '0 : bias_mem[bias_addr[IDX_W-1:0]];
    end
  end

  // A fresh load clears the error flag, but an error in the same cycle still sets it.
  always_ff @(posedge clk) begin
    if (!rst) begin
      rd_err_q <= 1'b0;
    end else begin
      if (state_q == IDLE && load_start)
        rd_err_q <= 1'b0;
      if ((weight_ren && w_bad) || (bias_ren && b_bad))
        rd_err_q <= 1'b1;
    end
  end

  assign load_done   = load_done_q;
  assign loaded      = loaded_q;
  assign rd_err      = rd_err_q;
  assign weight_data = weight_data_q;
  assign bias_data   = bias_data_q;

endmodule

// File: tb/tb_layer_param_store.sv
// Directed bench for layer_param_store: loads, reads, bursty host, read errors,
// reset mid-load and bias upper-bit masking with DEPTH=4, 64-bit weights, 32-bit beats.
module tb_layer_param_store;

  logic        clk = 1'b0;
  logic        rst;
  logic        load_start;
  logic [31:0] host_data;
  logic        host_valid;
  logic        host_ready;
  logic        load_done;
  logic        loaded;
  logic        busy;
  logic        weight_ren;
  logic [2:0]  weight_addr;
  logic [63:0] weight_data;
  logic        bias_ren;
  logic [2:0]  bias_addr;
  logic [1:0]  bias_data;
  logic        rd_err;

  int checks = 0;
  int errors = 0;
  int done_cnt = 0;

  logic [31:0] beats [12];
  logic [63:0] exp_w [4];
  logic [1:0]  exp_b [4];

  layer_param_store #(
    .DEPTH(4), .WEIGHT_DATA_WIDTH(64), .BIAS_DATA_WIDTH(2),
    .ADDR_WIDTH(3), .HOST_WIDTH(32)
  ) dut (
    .clk(clk), .rst(rst), .load_start(load_start),
    .host_data(host_data), .host_valid(host_valid), .host_ready(host_ready),
    .load_done(load_done), .loaded(loaded), .busy(busy),
    .weight_ren(weight_ren), .weight_addr(weight_addr), .weight_data(weight_data),
    .bias_ren(bias_ren), .bias_addr(bias_addr), .bias_data(bias_data),
    .rd_err(rd_err)
  );

  always #5 clk = ~clk;

  always @(negedge clk) if (load_done) done_cnt++;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic send(input logic [31:0] d);
    host_data  = d;
    host_valid = 1'b1;
    step();
    host_valid = 1'b0;
    host_data  = 32'hDEADBEEF;
  endtask

  task automatic start_load();
    load_start = 1'b1;
    step();
    load_start = 1'b0;
    check("start_busy", 64'(busy), 64'd1);
    check("start_ready", 64'(host_ready), 64'd1);
    check("start_loaded", 64'(loaded), 64'd0);
    check("start_rderr", 64'(rd_err), 64'd0);
  endtask

  // Full load from beats[]; bursty inserts idle gaps and stray load_start pulses,
  // bias_probe issues a bias read during the bias phase.
  task automatic run_load(input bit bursty, input bit bias_probe);
    start_load();
    for (int k = 0; k < 8; k++) begin
      if (bursty && (k % 2 == 1)) begin
        if (k == 3) load_start = 1'b1;
        step();
        load_start = 1'b0;
        check("gap_busy", 64'(busy), 64'd1);
        step();
        check("gap_busy", 64'(busy), 64'd1);
      end
      send(beats[k]);
      if (bursty) check("w_busy", 64'(busy), 64'd1);
    end
    for (int k = 0; k < 4; k++) begin
      if (bias_probe && k == 0) begin
        bias_ren  = 1'b1;
        bias_addr = 3'd1;
      end
      if (bursty && k == 1) load_start = 1'b1;
      send(beats[8+k]);
      load_start = 1'b0;
      if (bias_probe && k == 0) begin
        bias_ren = 1'b0;
        check("busy_bias_data", 64'(bias_data), 64'd0);
        check("busy_bias_rderr", 64'(rd_err), 64'd1);
      end
      if (k < 3) check("b_busy", 64'(busy), 64'd1);
    end
    check("done_pulse", 64'(load_done), 64'd1);
    check("done_loaded", 64'(loaded), 64'd1);
    check("done_busy", 64'(busy), 64'd0);
    check("done_ready", 64'(host_ready), 64'd0);
    step();
    check("done_drop", 64'(load_done), 64'd0);
    check("idle_ready", 64'(host_ready), 64'd0);
  endtask

  task automatic read_all();
    for (int i = 0; i < 4; i++) begin
      weight_ren  = 1'b1;
      bias_ren    = 1'b1;
      weight_addr = 3'(i);
      bias_addr   = 3'(i);
      step();
      check($sformatf("rd_w%0d", i), weight_data, exp_w[i]);
      check($sformatf("rd_b%0d", i), 64'(bias_data), 64'(exp_b[i]));
    end
    weight_ren = 1'b0;
    bias_ren   = 1'b0;
    weight_addr = 3'd0;
    bias_addr   = 3'd0;
    step();
    check("hold_w", weight_data, exp_w[3]);
    check("hold_b", 64'(bias_data), 64'(exp_b[3]));
  endtask

  task automatic std_beats();
    for (int k = 0; k < 8; k++) beats[k] = 32'(k);
    beats[8] = 32'h3; beats[9] = 32'h2; beats[10] = 32'h1; beats[11] = 32'h0;
    exp_w[0] = 64'h00000001_00000000;
    exp_w[1] = 64'h00000003_00000002;
    exp_w[2] = 64'h00000005_00000004;
    exp_w[3] = 64'h00000007_00000006;
    exp_b[0] = 2'd3; exp_b[1] = 2'd2; exp_b[2] = 2'd1; exp_b[3] = 2'd0;
  endtask

  initial begin
    rst = 1'b0; load_start = 1'b0; host_data = 32'h0; host_valid = 1'b0;
    weight_ren = 1'b0; weight_addr = 3'd0; bias_ren = 1'b0; bias_addr = 3'd0;
    step();
    step();
    check("rst_ready", 64'(host_ready), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_loaded", 64'(loaded), 64'd0);
    check("rst_done", 64'(load_done), 64'd0);
    check("rst_rderr", 64'(rd_err), 64'd0);
    check("rst_wdata", weight_data, 64'd0);
    check("rst_bdata", 64'(bias_data), 64'd0);
    rst = 1'b1;
    step();

    // 1: full load with valid held high
    std_beats();
    run_load(1'b0, 1'b0);
    check("s1_done_cnt", 64'(done_cnt), 64'd1);
    $display("scenario 1 full load: done_cnt=%0d loaded=%0b", done_cnt, loaded);

    // 2: back-to-back reads then hold
    read_all();
    check("s2_rderr", 64'(rd_err), 64'd0);
    $display("scenario 2 reads: w3=%h b3=%0d rd_err=%0b", weight_data, bias_data, rd_err);

    // 3: bursty host with stray load_start pulses
    run_load(1'b1, 1'b0);
    check("s3_done_cnt", 64'(done_cnt), 64'd2);
    read_all();
    $display("scenario 3 bursty load: done_cnt=%0d", done_cnt);

    // 4: out-of-range read, then bias read during LOAD_B; bias beat 0xFFFFFFFE masks to 2
    weight_ren = 1'b1; weight_addr = 3'd5;
    bias_ren   = 1'b1; bias_addr   = 3'd0;
    step();
    weight_ren = 1'b0; bias_ren = 1'b0;
    check("oob_wdata", weight_data, 64'd0);
    check("oob_rderr", 64'(rd_err), 64'd1);
    check("inrange_bdata", 64'(bias_data), 64'd3);
    step();
    check("rderr_sticky", 64'(rd_err), 64'd1);
    beats[8] = 32'hFFFFFFFE;
    exp_b[0] = 2'd2;
    run_load(1'b0, 1'b1);
    check("rderr_after_load", 64'(rd_err), 64'd1);
    read_all();
    check("s4_done_cnt", 64'(done_cnt), 64'd3);
    $display("scenario 4 read errors: rd_err=%0b bias0=%0d", rd_err, exp_b[0]);

    // 5: reset after 5 beats, partial contents survive, then reload
    start_load();
    for (int k = 0; k < 5; k++) send(32'h55 + 32'(k));
    rst = 1'b0;
    step();
    rst = 1'b1;
    check("mid_rst_busy", 64'(busy), 64'd0);
    check("mid_rst_loaded", 64'(loaded), 64'd0);
    check("mid_rst_ready", 64'(host_ready), 64'd0);
    check("mid_rst_done", 64'(load_done), 64'd0);
    check("mid_rst_rderr", 64'(rd_err), 64'd0);
    check("mid_rst_wdata", weight_data, 64'd0);
    check("mid_rst_bdata", 64'(bias_data), 64'd0);
    weight_ren = 1'b1; weight_addr = 3'd0;
    step();
    check("partial_w0", weight_data, 64'h00000056_00000055);
    weight_addr = 3'd2;
    step();
    weight_ren = 1'b0;
    check("partial_w2", weight_data, 64'h00000005_00000004);
    check("partial_rderr", 64'(rd_err), 64'd0);
    for (int k = 0; k < 8; k++) beats[k] = 32'hA0 + 32'(k);
    beats[8] = 32'h1; beats[9] = 32'h0; beats[10] = 32'h3; beats[11] = 32'h2;
    exp_w[0] = 64'h000000A1_000000A0;
    exp_w[1] = 64'h000000A3_000000A2;
    exp_w[2] = 64'h000000A5_000000A4;
    exp_w[3] = 64'h000000A7_000000A6;
    exp_b[0] = 2'd1; exp_b[1] = 2'd0; exp_b[2] = 2'd3; exp_b[3] = 2'd2;
    run_load(1'b0, 1'b0);
    check("s5_done_cnt", 64'(done_cnt), 64'd4);
    read_all();
    $display("scenario 5 reset mid-load and reload: done_cnt=%0d", done_cnt);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/layer_param_store.md
Name: layer_param_store

Overview:
Per-layer parameter memory that answers the layer controller's weight/bias read requests (ren + addr in, data out one cycle later). It is also the write side of that interface. A host stream loader fills the weight and bias arrays: narrow host beats are assembled into wide weight words, followed by the bias entries. One instance sits behind each layer's weight/bias ports.

Parameters:
DEPTH, 1024, number of neurons, i.e. weight words and bias entries in the layer
WEIGHT_DATA_WIDTH, 512, bits per weight word; must be an integer multiple of HOST_WIDTH
BIAS_DATA_WIDTH, 2, bits per bias entry; must be <= HOST_WIDTH
ADDR_WIDTH, 10, read address width
HOST_WIDTH, 32, host load beat width

Ports:
clk  in  1  clock
rst  in  1  reset, synchronous, active-low
load_start  in  1  one-cycle pulse that begins a full load
host_data  in  HOST_WIDTH  load beat
host_valid  in  1  beat valid
host_ready  out  1  store accepts beat
load_done  out  1  one-cycle pulse when the last bias beat is written
loaded  out  1  array holds a complete load
busy  out  1  load in progress
weight_ren  in  1  weight read enable
weight_addr  in  ADDR_WIDTH  weight read address
weight_data  out  WEIGHT_DATA_WIDTH  weight read data
bias_ren  in  1  bias read enable
bias_addr  in  ADDR_WIDTH  bias read address
bias_data  out  BIAS_DATA_WIDTH  bias read data
rd_err  out  1  sticky: a read was issued while busy or out of range

Behaviour:
- Reset (rst=0 at posedge clk):
  - state=IDLE; host_ready, load_done, loaded, busy and rd_err all 0.
  - weight_data=0, bias_data=0; counters 0.
  - Array contents are not cleared.
- FSM states: IDLE, LOAD_W, LOAD_B.
- IDLE:
  - load_start=1 -> LOAD_W; beat_cnt=0, word_addr=0, loaded<=0, rd_err<=0.
  - Otherwise stay in IDLE.
- Handshake: host_ready=1 exactly in LOAD_W and LOAD_B. A beat transfers when host_valid && host_ready at posedge. host_data may change freely while host_valid=0.
- LOAD_W: BEATS = WEIGHT_DATA_WIDTH/HOST_WIDTH beats per word, least-significant beat first.
  - Beat k lands in bits [k*HOST_WIDTH +: HOST_WIDTH].
  - On the last beat of a word, the assembled word (including that beat) is written to weight[word_addr] in the same cycle. Then word_addr++ and beat_cnt=0.
  - After word DEPTH-1 is written -> LOAD_B with word_addr=0.
- LOAD_B: one beat per entry; bias[word_addr] = host_data[BIAS_DATA_WIDTH-1:0] and upper bits are ignored.
  - After entry DEPTH-1: -> IDLE, load_done=1 for exactly one cycle, loaded=1 from that same cycle.
- busy=1 in LOAD_W and LOAD_B.
- load_start while busy is ignored; the load continues unchanged.
- Reset mid-load: return to IDLE with loaded=0; partially written contents are left in the array.
- Read ports, weight and bias independent, both 1-cycle latency:
  - ren=1 at posedge N -> data valid after posedge N+1, holding mem[addr sampled at N].
  - ren=0 -> data holds its previous value.
  - Back-to-back ren gives one new word per cycle.
- Read-error rules:
  - ren=1 while busy=1 -> data<=0 and rd_err<=1.
  - ren=1 with addr >= DEPTH -> data<=0 and rd_err<=1.
  - rd_err clears only on reset or load_start.
- A read while loaded=0 and not busy returns the array contents without error.
- No read/write collision is possible, because reads during busy are rejected.
- Address wrap: the counters never exceed DEPTH-1. ADDR_WIDTH must satisfy 2^ADDR_WIDTH >= DEPTH.

Test Plan:
(Parameters for all scenarios: DEPTH=4, WEIGHT_DATA_WIDTH=64, HOST_WIDTH=32, BIAS_DATA_WIDTH=2, ADDR_WIDTH=3.)
1. Full load, host_valid held high. Load start + 12 beats: 0x0..0x7 for weights, then 0x3,0x2,0x1,0x0 for bias.
   -> load_done pulses once on the cycle after beat 12; loaded=1.
   -> weight[0]=0x00000001_00000000, weight[3]=0x00000007_00000006; bias[0..3]=3,2,1,0.
2. Read after load: weight_ren and bias_ren high for 4 cycles, addr 0..3.
   -> data appears one cycle later, a new value each cycle.
   -> Drop ren: data holds weight[3]/bias[3]. rd_err=0.
3. Bursty host: host_valid toggles 1,0,0,1 during LOAD_W; extra load_start pulses mid-load.
   -> Same array contents as scenario 1; a single load_done.
   -> busy stays 1 throughout; host_ready=0 after completion.
4. Read errors:
   -> weight_ren with weight_addr=5 -> weight_data=0, rd_err=1.
   -> bias_ren during LOAD_B -> bias_data=0, rd_err stays 1 until the next load_start.
5. Reset mid-load: rst=0 after 5 beats.
   -> IDLE, busy=0, loaded=0, host_ready=0, outputs 0.
   -> A subsequent full load then completes correctly with load_done.
6. Bias upper bits: bias beat 0xFFFFFFFE -> bias[0]=2.
